sram_ctrl_burst: RTL and testbench

//  Parametrised asynchronous-SRAM controller. Successor to the 16-bit single-access controller.

---
 rtl/sram_ctrl_pkg.sv | 26 ++
 rtl/sram_dq_io.sv | 27 ++
 rtl/sram_ctrl_burst.sv | 217 +++++++++++++++++++++
 tb/tb_sram_ctrl_burst.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the asynchronous SRAM controller.
//   state_e    : controller FSM states (3-bit encoding)
//   RW_READ/RW_WRITE : values of req_rw
//   clog2      : ceiling log2, used for counter widths
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_WR       = 3'd2,
    ST_WR_HOLD  = 3'd3,
    ST_WR_STALL = 3'd4,
    ST_TURN     = 3'd5
  } state_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/sram_dq_io.sv
// Tri-state data pad driver and read capture register.
//   clk, reset : clock, synchronous active-high reset
//   drive      : registered drive flag; dq is driven with wdata while high
//   wdata      : write data presented on the bus
//   cap        : capture dq into rd_data at this edge
//   rd_data    : last captured read word
//   dq         : bidirectional SRAM data bus
module sram_dq_io #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              drive,
  input  logic [DATA_W-1:0] wdata,
  input  logic              cap,
  output logic [DATA_W-1:0] rd_data,
  inout  wire  [DATA_W-1:0] dq
);

  assign dq = drive ? wdata : {DATA_W{1'bz}};

  always_ff @(posedge clk) begin
    if (reset)    rd_data <= '0;
    else if (cap) rd_data <= dq;
  end

endmodule

// File: rtl/sram_ctrl_burst.sv
// Parametrised asynchronous-SRAM controller with wait states, byte enables,
// write-to-read turnaround and optional incrementing bursts.
// Optional feature macro: SRAM_BURST_EN (req_len and the wr_* stream honoured).
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   req_valid/req_ready : request handshake (ready only in IDLE)
//   req_rw/addr/len/wdata/be : request; 1=read, beats-1, beat-0 data, byte enables
//   wr_valid/wr_ready/wr_data : write data stream for burst beats 1..N
//   rd_valid/rd_data/rd_last  : read beat output, no back-pressure
//   sram_addr/dq/ce_n/oe_n/we_n/be_n : SRAM pins (controls registered)
module sram_ctrl_burst
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 18,
  parameter int WAIT_CYC = 1,
  parameter int TURN_CYC = 1,
  parameter int LEN_W    = 4,
  localparam int NB      = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [NB-1:0]     req_be,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_dq,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [NB-1:0]     sram_be_n
);

  localparam int CNT_MAX = (WAIT_CYC > TURN_CYC) ? WAIT_CYC : TURN_CYC;
  localparam int CNT_W   = clog2(CNT_MAX + 1);
  localparam int BC_W    = LEN_W + 1;
  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] TURN_LD = CNT_W'((TURN_CYC == 0) ? 0 : TURN_CYC - 1);

  generate
    if (WAIT_CYC < 1 || (DATA_W % 8) != 0) begin : g_bad_cfg
      $error("sram_ctrl_burst: WAIT_CYC must be >=1 and DATA_W a multiple of 8");
    end
  endgenerate

  state_e            state;
  logic [CNT_W-1:0]  cnt;        // wait / turnaround cycles left minus one
  logic [BC_W-1:0]   beat_cnt;   // beats left including the current one
  logic [DATA_W-1:0] wdata;
  logic              drive;
  logic              cap;
  logic              more;

  assign more = (beat_cnt != BC_W'(1));
  // Capture on the edge that ends the last wait cycle of each read beat.
  assign cap  = (state == ST_RD) && (cnt == '0);

`ifdef SRAM_BURST_EN
  // Beat handoff is combinational on wr_valid so a waiting producer is taken
  // in the same cycle it presents data.
  assign wr_ready = !reset && wr_valid &&
                    (((state == ST_WR_HOLD) && more) || (state == ST_WR_STALL));
`else
  assign wr_ready = 1'b0;
  logic unused_burst;
  assign unused_burst = ^{req_len, wr_valid, wr_data};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      beat_cnt  <= '0;
      wdata     <= '0;
      drive     <= 1'b0;
      sram_addr <= '0;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_be_n <= '1;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
      req_ready <= 1'b0;
    end else begin
      sram_ce_n <= 1'b0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
      case (state)
        ST_IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            sram_addr <= req_addr;
            sram_be_n <= ~req_be;
            wdata     <= req_wdata;
            cnt       <= WAIT_LD;
`ifdef SRAM_BURST_EN
            beat_cnt  <= BC_W'(req_len) + 1'b1;
`else
            beat_cnt  <= BC_W'(1);
`endif
            if (req_rw == RW_READ) begin
              sram_oe_n <= 1'b0;
              state     <= ST_RD;
            end else begin
              sram_we_n <= 1'b0;
              drive     <= 1'b1;
              state     <= ST_WR;
            end
          end
        end
        ST_RD: begin
          if (cnt == '0) begin
            rd_valid <= 1'b1;
            rd_last  <= !more;
            if (more) begin
              // oe_n stays low across beats; address wraps naturally.
              sram_addr <= sram_addr + 1'b1;
              beat_cnt  <= beat_cnt - 1'b1;
              cnt       <= WAIT_LD;
            end else begin
              sram_oe_n <= 1'b1;
              req_ready <= 1'b1;
              state     <= ST_IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_WR: begin
          if (cnt == '0) begin
            sram_we_n <= 1'b1;
            state     <= ST_WR_HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_WR_HOLD: begin
`ifdef SRAM_BURST_EN
          if (more) begin
            if (wr_ready) begin
              wdata     <= wr_data;
              sram_addr <= sram_addr + 1'b1;
              beat_cnt  <= beat_cnt - 1'b1;
              cnt       <= WAIT_LD;
              sram_we_n <= 1'b0;
              state     <= ST_WR;
            end else begin
              drive <= 1'b0;
              state <= ST_WR_STALL;
            end
          end else
`endif
          begin
            drive <= 1'b0;
            if (TURN_CYC == 0) begin
              req_ready <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              cnt   <= TURN_LD;
              state <= ST_TURN;
            end
          end
        end
`ifdef SRAM_BURST_EN
        ST_WR_STALL: begin
          if (wr_ready) begin
            wdata     <= wr_data;
            sram_addr <= sram_addr + 1'b1;
            beat_cnt  <= beat_cnt - 1'b1;
            cnt       <= WAIT_LD;
            sram_we_n <= 1'b0;
            drive     <= 1'b1;
            state     <= ST_WR;
          end
        end
`endif
        ST_TURN: begin
          if (cnt == '0) begin
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          drive     <= 1'b0;
          sram_oe_n <= 1'b1;
          sram_we_n <= 1'b1;
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  sram_dq_io #(.DATA_W(DATA_W)) u_dq (
    .clk     (clk),
    .reset   (reset),
    .drive   (drive),
    .wdata   (wdata),
    .cap     (cap),
    .rd_data (rd_data),
    .dq      (sram_dq)
  );

endmodule

// File: tb/tb_sram_ctrl_burst.sv
// Directed bench for sram_ctrl_burst (WAIT_CYC=2, TURN_CYC=1) with a small
// behavioural SRAM on the pins. Burst scenarios need SRAM_BURST_EN.
module tb_sram_ctrl_burst;

  localparam int DW = 16, AW = 18, LW = 4;

  logic          clk = 1'b0, reset = 1'b1;
  logic          req_valid = 1'b0, req_rw = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [LW-1:0] req_len = '0;
  logic [DW-1:0] req_wdata = '0, wr_data = '0;
  logic [1:0]    req_be = '0;
  logic          wr_valid = 1'b0;
  logic          req_ready, wr_ready, rd_valid, rd_last;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] sram_addr;
  wire  [DW-1:0] sram_dq;
  logic          sram_ce_n, sram_oe_n, sram_we_n;
  logic [1:0]    sram_be_n;

  always #5 clk = ~clk;

  sram_ctrl_burst #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYC(2), .TURN_CYC(1), .LEN_W(LW)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_rw(req_rw), .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
    .req_be(req_be), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .sram_addr(sram_addr),
    .sram_dq(sram_dq), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
  );

  // Behavioural SRAM, 256 words aliased on the low address bits.
  logic [DW-1:0] mem [0:255];
  assign sram_dq = (!sram_oe_n && !sram_ce_n && sram_we_n) ? mem[sram_addr[7:0]] : {DW{1'bz}};
  always @(posedge clk)
    if (!sram_ce_n && !sram_we_n)
      for (int b = 0; b < 2; b++)
        if (!sram_be_n[b]) mem[sram_addr[7:0]][8*b +: 8] <= sram_dq[8*b +: 8];

  int n_cmp = 0, n_err = 0, n_cont = 0, n_wrr = 0;
  always @(negedge clk) begin
    if (!sram_oe_n && u_dut.drive) n_cont++;
    if (wr_ready) n_wrr++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step(); @(posedge clk); #1; endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  int last_wait;
  task automatic wait_ready();
    last_wait = 0;
    while (!req_ready && last_wait < 50) begin step(); last_wait++; end
    if (!req_ready) chk("req_ready_timeout", 32'(req_ready), 32'd1);
  endtask

  int wr_we, wr_drv, wr_busy;
  logic [1:0] wr_ben;
  logic [AW-1:0] wr_a0;
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] be);
    req_rw = 1'b0; req_addr = a; req_wdata = d; req_be = be; req_len = '0; req_valid = 1'b1;
    wait_ready();
    step();
    req_valid = 1'b0;
    wr_ben = sram_be_n; wr_a0 = sram_addr; wr_we = 0; wr_drv = 0; wr_busy = 0;
    while (!req_ready && wr_busy < 30) begin
      if (!sram_we_n) wr_we++;
      if (u_dut.drive) wr_drv++;
      step(); wr_busy++;
    end
  endtask

  logic [DW-1:0] rq_d[$];
  logic          rq_l[$];
  int            rq_k[$];
  logic [AW-1:0] rq_a[$];
  int            rd_oe;
  task automatic do_read(input logic [AW-1:0] a, input logic [LW-1:0] len);
    logic [AW-1:0] pa;
    req_rw = 1'b1; req_addr = a; req_len = len; req_valid = 1'b1;
    wait_ready();
    step();
    req_valid = 1'b0;
    rq_d.delete(); rq_l.delete(); rq_k.delete(); rq_a.delete(); rd_oe = 0;
    pa = sram_addr;
    for (int k = 0; k < 2 * (int'(len) + 1) + 4; k++) begin
      if (rd_valid) begin
        rq_d.push_back(rd_data); rq_l.push_back(rd_last);
        rq_k.push_back(k); rq_a.push_back(pa);
      end
      if (!sram_oe_n) rd_oe++;
      pa = sram_addr;
      step();
    end
  endtask

  logic [AW-1:0] exp_a [4] = '{18'h3FFFE, 18'h3FFFF, 18'h00000, 18'h00001};
  int wrr0;

  initial begin
    // Reset state
    step(); step();
    chk("rst_oe_n", 32'(sram_oe_n), 32'd1);
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_be_n", 32'(sram_be_n), 32'h3);
    chk("rst_ce_n", 32'(sram_ce_n), 32'd1);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    chk("rst_drive", 32'(u_dut.drive), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_last", 32'(rd_last), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    reset = 1'b0;
    step();
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    chk("post_rst_ce_n", 32'(sram_ce_n), 32'd0);

    // 1: single write then read
    do_write(18'h00010, 16'h1234, 2'b11);
    chk("t1_we_low_cycles", 32'(wr_we), 32'd2);
    chk("t1_dq_drive_cycles", 32'(wr_drv), 32'd3);
    chk("t1_busy_cycles", 32'(wr_busy), 32'd4);
    chk("t1_addr", 32'(wr_a0), 32'h10);
    chk("t1_be_n", 32'(wr_ben), 32'h0);
    do_read(18'h00010, 4'd0);
    chk("t1_rd_beats", 32'(rq_d.size()), 32'd1);
    chk("t1_rd_data", 32'(rq_d[0]), 32'h1234);
    chk("t1_rd_latency", 32'(rq_k[0]), 32'd2);
    chk("t1_rd_last", 32'(rq_l[0]), 32'd1);
    chk("t1_oe_cycles", 32'(rd_oe), 32'd2);

    // 2: byte enables
    do_write(18'h00020, 16'hAAAA, 2'b11);
    do_write(18'h00020, 16'h5555, 2'b01);
    chk("t2_be_n", 32'(wr_ben), 32'h2);
    do_read(18'h00020, 4'd0);
    chk("t2_rd_data", 32'(rq_d[0]), 32'hAA55);

`ifdef SRAM_BURST_EN
    // 3: burst read across the address wrap
    for (int i = 0; i < 4; i++) do_write(exp_a[i], 16'hC000 + 16'(i), 2'b11);
    do_read(18'h3FFFE, 4'd3);
    chk("t3_beats", 32'(rq_d.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t3_addr", 32'(rq_a[i]), 32'(exp_a[i]));
      chk("t3_data", 32'(rq_d[i]), 32'hC000 + i);
      chk("t3_last", 32'(rq_l[i]), (i == 3) ? 32'd1 : 32'd0);
      chk("t3_spacing", 32'(rq_k[i]), 32'(2 + 2 * i));
    end

    // 4: burst write with a stalled data stream
    wrr0 = n_wrr;
    req_rw = 1'b0; req_addr = 18'h00040; req_wdata = 16'hD000; req_be = 2'b11;
    req_len = 4'd2; req_valid = 1'b1;
    wait_ready();
    step();
    req_valid = 1'b0;
    step(); step(); step();
    chk("t4_stall_we_n", 32'(sram_we_n), 32'd1);
    chk("t4_stall_dq_hiz", 32'(u_dut.drive), 32'd0);
    chk("t4_stall_wr_ready", 32'(wr_ready), 32'd0);
    wr_valid = 1'b1; wr_data = 16'hD001;
    #1;
    chk("t4_resume_wr_ready", 32'(wr_ready), 32'd1);
    step();
    wr_data = 16'hD002;
    for (int k = 0; k < 20 && !wr_ready; k++) step();
    step();
    wr_valid = 1'b0;
    wait_ready();
    chk("t4_wr_ready_pulses", 32'(n_wrr - wrr0), 32'd2);
    do_read(18'h00040, 4'd2);
    chk("t4_beats", 32'(rq_d.size()), 32'd3);
    for (int i = 0; i < 3; i++) chk("t4_data", 32'(rq_d[i]), 32'hD000 + i);
`endif

    // 5: reset during the first RD cycle
    req_rw = 1'b1; req_addr = 18'h00060; req_len = 4'd3; req_valid = 1'b1;
    wait_ready();
    step();
    req_valid = 1'b0;
    chk("t5_in_rd_oe_n", 32'(sram_oe_n), 32'd0);
    reset = 1'b1;
    step();
    chk("t5_rst_oe_n", 32'(sram_oe_n), 32'd1);
    chk("t5_rst_dq_hiz", 32'(u_dut.drive), 32'd0);
    chk("t5_rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("t5_rst_req_ready", 32'(req_ready), 32'd0);
    reset = 1'b0;
    step();
    chk("t5_ready_after_rst", 32'(req_ready), 32'd1);
    begin
      int rv = 0;
      for (int k = 0; k < 8; k++) begin if (rd_valid) rv++; step(); end
      chk("t5_no_rd_valid", 32'(rv), 32'd0);
    end

    // 6: write followed by a queued read
    req_rw = 1'b0; req_addr = 18'h00050; req_wdata = 16'hBEEF; req_be = 2'b11;
    req_len = '0; req_valid = 1'b1;
    wait_ready();
    step();
    do_read(18'h00050, 4'd0);
    chk("t6_ready_low_cycles", 32'(last_wait), 32'd4);
    chk("t6_rd_data", 32'(rq_d[0]), 32'hBEEF);
    chk("t6_rd_latency", 32'(rq_k[0]), 32'd2);
    chk("bus_contention", 32'(n_cont), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
